// File: rtl/relm_div_pkg.sv
// Shared types and helpers for the relm_div_seq radix-4 divider.
// Compile-time option: RELM_DIV_SIGNED_EN enables two's-complement operands and the FIX state.
package relm_div_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ALIGN = 3'd1,
        LOOP  = 3'd2,
        FIX   = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Leading-one detector input width; operands up to this width are supported.
    localparam int MSB_VW = 64;
    localparam int MSB_IW = 7;

`ifdef RELM_DIV_SIGNED_EN
    localparam bit HAS_FIX = 1'b1;
`else
    localparam bit HAS_FIX = 1'b0;
`endif

    // Prefix-OR from the top, then count the ones: the count minus one is the msb index.
    function automatic logic [MSB_IW-1:0] msb_index(input logic [MSB_VW-1:0] v);
        logic [MSB_VW-1:0] pre;
        logic [MSB_IW-1:0] cnt;
        pre[MSB_VW-1] = v[MSB_VW-1];
        for (int i = MSB_VW - 2; i >= 0; i--) begin
            pre[i] = pre[i+1] | v[i];
        end
        cnt = '0;
        for (int i = 0; i < MSB_VW; i++) begin
            cnt = cnt + MSB_IW'(pre[i]);
        end
        return cnt - MSB_IW'(1);
    endfunction

endpackage

// File: rtl/relm_div_step.sv
// Combinational radix-4 step: retires quotient bits qbit and qbit>>1 against the aligned divisor.
module relm_div_step #(
    parameter int WD = 32
) (
    input  logic [WD-1:0] rem,
    input  logic [WD-1:0] dq,
    input  logic [WD-1:0] qbit,
    output logic [WD-1:0] rem_next,
    output logic [WD-1:0] qbits
);

    logic [WD:0]   dq3;
    logic [WD-1:0] dq_half;
    logic [WD-1:0] qbit_half;

    // Dq + Dq/2 can carry past WD bits, so it is compared one bit wider.
    assign dq3       = {1'b0, dq} + {2'b00, dq[WD-1:1]};
    assign dq_half   = dq >> 1;
    assign qbit_half = qbit >> 1;

    always_comb begin
        rem_next = rem;
        qbits    = '0;
        if (qbit[0]) begin
            // Final single-bit step: Dq/2 would be truncated, so only Dq is tried.
            if (rem >= dq) begin
                rem_next = rem - dq;
                qbits    = qbit;
            end
        end else if ({1'b0, rem} >= dq3) begin
            rem_next = rem - dq3[WD-1:0];
            qbits    = qbit | qbit_half;
        end else if (rem >= dq) begin
            rem_next = rem - dq;
            qbits    = qbit;
        end else if (rem >= dq_half) begin
            rem_next = rem - dq_half;
            qbits    = qbit_half;
        end
    end

endmodule

// File: rtl/relm_div_seq.sv
// Self-sequencing radix-4 integer divider with a start/done handshake.
// Compile-time option: RELM_DIV_SIGNED_EN (signed operands, extra FIX cycle).
//
// Handshake: a request is taken on a rising edge where start_in=1 and the block is
// in IDLE or DONE; busy_out is high from ALIGN until the result is ready, and
// done_out is a one-cycle pulse in DONE with q_out/r_out/dz_out valid and held.
module relm_div_seq
    import relm_div_pkg::*;
#(
    parameter int WD = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_in,
    input  logic [WD-1:0] n_in,
    input  logic [WD-1:0] d_in,
    output logic          busy_out,
    output logic          done_out,
    output logic [WD-1:0] q_out,
    output logic [WD-1:0] r_out,
    output logic          dz_out,
    output state_t        state_dbg
);

    state_t        state;
    logic [WD-1:0] n_q, d_q, n_raw;
    logic          neg_q, neg_r, dz_q;
    logic [WD-1:0] rem, dq, qbit, quo;

    logic [WD-1:0]     n_abs, d_abs;
    logic [MSB_IW-1:0] n_msb, d_msb, k;
    logic [WD-1:0]     step_rem, step_bits;
    logic              last_step, trivial, finish;
    logic [WD-1:0]     fin_quo, fin_rem;
    logic              fin_dz;

    assign state_dbg = state;

    // Magnitudes are divided; the signs are reapplied in FIX.
    assign n_abs = (HAS_FIX && n_in[WD-1]) ? -n_in : n_in;
    assign d_abs = (HAS_FIX && d_in[WD-1]) ? -d_in : d_in;

    assign n_msb = msb_index(MSB_VW'(n_q));
    assign d_msb = msb_index(MSB_VW'(d_q));
    assign k     = n_msb - d_msb;

    assign trivial   = (d_q == '0) || (n_q < d_q);
    assign last_step = (qbit[WD-1:2] == '0);
    assign finish    = ((state == ALIGN) && trivial) || ((state == LOOP) && last_step);

    relm_div_step #(.WD(WD)) u_step (
        .rem      (rem),
        .dq       (dq),
        .qbit     (qbit),
        .rem_next (step_rem),
        .qbits    (step_bits)
    );

    always_comb begin
        fin_quo = quo | step_bits;
        fin_rem = step_rem;
        fin_dz  = 1'b0;
        if (state == ALIGN) begin
            fin_quo = (d_q == '0) ? '1 : '0;
            fin_rem = n_q;
            fin_dz  = (d_q == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            busy_out <= 1'b0;
            done_out <= 1'b0;
            q_out    <= '0;
            r_out    <= '0;
            dz_out   <= 1'b0;
            n_q      <= '0;
            d_q      <= '0;
            n_raw    <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            dz_q     <= 1'b0;
            rem      <= '0;
            dq       <= '0;
            qbit     <= '0;
            quo      <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done_out <= 1'b0;
                    if (start_in) begin
                        n_q      <= n_abs;
                        d_q      <= d_abs;
                        n_raw    <= n_in;
                        neg_q    <= HAS_FIX && (n_in[WD-1] ^ d_in[WD-1]);
                        neg_r    <= HAS_FIX && n_in[WD-1];
                        dz_out   <= 1'b0;
                        busy_out <= 1'b1;
                        state    <= ALIGN;
                    end else begin
                        state <= IDLE;
                    end
                end
                ALIGN: begin
                    if (!trivial) begin
                        dq    <= d_q << k;
                        qbit  <= WD'(1) << k;
                        quo   <= '0;
                        rem   <= n_q;
                        state <= LOOP;
                    end
                end
                LOOP: begin
                    rem  <= step_rem;
                    quo  <= quo | step_bits;
                    dq   <= dq >> 2;
                    qbit <= qbit >> 2;
                end
                FIX: begin
                    q_out    <= (neg_q && !dz_q) ? -quo : quo;
                    r_out    <= dz_q ? n_raw : (neg_r ? -rem : rem);
                    dz_out   <= dz_q;
                    done_out <= 1'b1;
                    busy_out <= 1'b0;
                    state    <= DONE;
                end
                default: begin
                    busy_out <= 1'b0;
                    done_out <= 1'b0;
                    state    <= IDLE;
                end
            endcase

            // Result hand-off, shared by the trivial ALIGN exit and the last LOOP step.
            if (finish) begin
                if (HAS_FIX) begin
                    quo   <= fin_quo;
                    rem   <= fin_rem;
                    dz_q  <= fin_dz;
                    state <= FIX;
                end else begin
                    q_out    <= fin_quo;
                    r_out    <= fin_rem;
                    dz_out   <= fin_dz;
                    done_out <= 1'b1;
                    busy_out <= 1'b0;
                    state    <= DONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_relm_div_seq.sv
// Self-checking bench for relm_div_seq: directed spec cases, back-to-back, mid-op reset, random ops.
// Honours RELM_DIV_SIGNED_EN for the reference model and the signed directed cases.
module tb_relm_div_seq;
    import relm_div_pkg::*;

    localparam int WD = 32;

    logic          clk;
    logic          rst;
    logic          start_in;
    logic [WD-1:0] n_in;
    logic [WD-1:0] d_in;
    logic          busy_out;
    logic          done_out;
    logic [WD-1:0] q_out;
    logic [WD-1:0] r_out;
    logic          dz_out;
    state_t        state_dbg;

    int checks = 0;
    int errors = 0;

    logic [2*WD:0] exp_q[$];

    relm_div_seq #(.WD(WD)) dut (
        .clk       (clk),
        .rst       (rst),
        .start_in  (start_in),
        .n_in      (n_in),
        .d_in      (d_in),
        .busy_out  (busy_out),
        .done_out  (done_out),
        .q_out     (q_out),
        .r_out     (r_out),
        .dz_out    (dz_out),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int msb_of(input logic [WD-1:0] v);
        for (int i = WD - 1; i >= 0; i--) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    function automatic int lat_of(input logic [WD-1:0] na, input logic [WD-1:0] da);
        int k;
        if (da == '0 || na < da) return 2;
        k = msb_of(na) - msb_of(da);
        return (k + 2) / 2 + 2;
    endfunction

    task automatic model(input logic [WD-1:0] n, input logic [WD-1:0] d,
                         output logic [WD-1:0] q, output logic [WD-1:0] r,
                         output logic dz, output int lat);
`ifdef RELM_DIV_SIGNED_EN
        logic signed [WD-1:0] sn, sd;
        logic [WD-1:0] na, da;
        sn = n;
        sd = d;
        na = n[WD-1] ? -n : n;
        da = d[WD-1] ? -d : d;
        dz = (d == '0);
        if (dz) begin
            q = '1;
            r = n;
        end else if (n == {1'b1, {(WD-1){1'b0}}} && d == '1) begin
            q = n;
            r = '0;
        end else begin
            q = sn / sd;
            r = sn % sd;
        end
        lat = lat_of(na, da) + 1;
`else
        dz = (d == '0);
        if (dz) begin
            q = '1;
            r = n;
        end else begin
            q = n / d;
            r = n % d;
        end
        lat = lat_of(n, d);
`endif
    endtask

    // ---------------- driver ----------------
    // Issues one request and follows it to done_out; lat=-1 means no done within the budget.
    task automatic drive_op(input logic [WD-1:0] n, input logic [WD-1:0] d,
                            output int lat, output logic [WD-1:0] q,
                            output logic [WD-1:0] r, output logic dz, output bit hs_ok);
        @(negedge clk);
        start_in = 1'b1;
        n_in     = n;
        d_in     = d;
        @(posedge clk);
        #1;
        start_in = 1'b0;
        lat   = -1;
        hs_ok = 1'b1;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (done_out) begin
                lat = c;
                if (busy_out) hs_ok = 1'b0;
                break;
            end else if (!busy_out) begin
                hs_ok = 1'b0;
            end
        end
        q  = q_out;
        r  = r_out;
        dz = dz_out;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst      = 1'b1;
        start_in = 1'b0;
        n_in     = '0;
        d_in     = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy_out); end
        checks++; if (done_out !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", done_out); end
        checks++; if (q_out !== '0) begin errors++; $display("FAIL reset_q got=%h want=0", q_out); end
        checks++; if (r_out !== '0) begin errors++; $display("FAIL reset_r got=%h want=0", r_out); end
        checks++; if (dz_out !== 1'b0) begin errors++; $display("FAIL reset_dz got=%b want=0", dz_out); end
        checks++; if (state_dbg !== IDLE) begin errors++; $display("FAIL reset_state got=%0d want=%0d", state_dbg, IDLE); end
    endtask

    typedef struct {
        logic [WD-1:0] n, d, q, r;
        logic          dz;
        int            lat;
    } vec_t;

    task automatic test_directed();
        vec_t vecs[5];
        int lat;
        logic [WD-1:0] q, r;
        logic dz;
        bit hs_ok;
`ifdef RELM_DIV_SIGNED_EN
        vecs[0] = '{n: 32'hFFFFFFF9, d: 32'd2,        q: 32'hFFFFFFFD, r: 32'hFFFFFFFF, dz: 1'b0, lat: 4};
        vecs[1] = '{n: 32'h80000000, d: 32'hFFFFFFFF, q: 32'h80000000, r: 32'd0,        dz: 1'b0, lat: 19};
        vecs[2] = '{n: 32'd7,        d: 32'hFFFFFFFE, q: 32'hFFFFFFFD, r: 32'd1,        dz: 1'b0, lat: 4};
        vecs[3] = '{n: 32'd1234,     d: 32'd0,        q: 32'hFFFFFFFF, r: 32'd1234,     dz: 1'b1, lat: 3};
        vecs[4] = '{n: 32'd5,        d: 32'd9,        q: 32'd0,        r: 32'd5,        dz: 1'b0, lat: 3};
`else
        vecs[0] = '{n: 32'd100,      d: 32'd7,        q: 32'd14,       r: 32'd2,        dz: 1'b0, lat: 5};
        vecs[1] = '{n: 32'd5,        d: 32'd9,        q: 32'd0,        r: 32'd5,        dz: 1'b0, lat: 2};
        vecs[2] = '{n: 32'hFFFFFFFF, d: 32'd1,        q: 32'hFFFFFFFF, r: 32'd0,        dz: 1'b0, lat: 18};
        vecs[3] = '{n: 32'd1234,     d: 32'd0,        q: 32'hFFFFFFFF, r: 32'd1234,     dz: 1'b1, lat: 2};
        vecs[4] = '{n: 32'd10,       d: 32'd3,        q: 32'd3,        r: 32'd1,        dz: 1'b0, lat: 4};
`endif
        foreach (vecs[i]) begin
            drive_op(vecs[i].n, vecs[i].d, lat, q, r, dz, hs_ok);
            checks++; if (lat !== vecs[i].lat) begin errors++; $display("FAIL dir%0d_latency got=%0d want=%0d", i, lat, vecs[i].lat); end
            checks++; if (q !== vecs[i].q) begin errors++; $display("FAIL dir%0d_q got=%h want=%h", i, q, vecs[i].q); end
            checks++; if (r !== vecs[i].r) begin errors++; $display("FAIL dir%0d_r got=%h want=%h", i, r, vecs[i].r); end
            checks++; if (dz !== vecs[i].dz) begin errors++; $display("FAIL dir%0d_dz got=%b want=%b", i, dz, vecs[i].dz); end
            checks++; if (hs_ok !== 1'b1) begin errors++; $display("FAIL dir%0d_busy_done got=%b want=1", i, hs_ok); end
            @(negedge clk);
            checks++; if (done_out !== 1'b0) begin errors++; $display("FAIL dir%0d_done_pulse got=%b want=0", i, done_out); end
            checks++; if (q_out !== vecs[i].q) begin errors++; $display("FAIL dir%0d_q_hold got=%h want=%h", i, q_out, vecs[i].q); end
        end
    endtask

    task automatic test_back_to_back();
        logic [WD-1:0] eq, er;
        logic edz;
        int elat, lat;
        model(32'd100, 32'd7, eq, er, edz, elat);
        @(negedge clk);
        start_in = 1'b1;
        n_in     = 32'd100;
        d_in     = 32'd7;
        @(posedge clk);
        #1;
        n_in = 32'd50;
        d_in = 32'd5;
        lat  = -1;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (done_out) begin lat = c; break; end
        end
        checks++; if (lat !== elat) begin errors++; $display("FAIL b2b_first_latency got=%0d want=%0d", lat, elat); end
        checks++; if (q_out !== eq || r_out !== er) begin errors++; $display("FAIL b2b_first_result got=%h/%h want=%h/%h", q_out, r_out, eq, er); end
        // start_in still high in the DONE cycle: the 50/5 request goes straight into ALIGN.
        model(32'd50, 32'd5, eq, er, edz, elat);
        @(posedge clk);
        #1;
        start_in = 1'b0;
        lat = -1;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (c == 1) begin
                checks++; if (state_dbg !== ALIGN) begin errors++; $display("FAIL b2b_no_bubble got=%0d want=%0d", state_dbg, ALIGN); end
            end
            if (done_out) begin lat = c; break; end
        end
        checks++; if (lat !== elat) begin errors++; $display("FAIL b2b_second_latency got=%0d want=%0d", lat, elat); end
        checks++; if (q_out !== 32'd10 || r_out !== 32'd0) begin errors++; $display("FAIL b2b_second_result got=%h/%h want=a/0", q_out, r_out); end
    endtask

    task automatic test_reset_mid();
        int lat, dones;
        logic [WD-1:0] q, r;
        logic dz;
        bit hs_ok;
        drive_op(32'd1000, 32'd7, lat, q, r, dz, hs_ok);
        @(negedge clk);
        start_in = 1'b1;
        n_in     = 32'hFFFFFFFF;
        d_in     = 32'd3;
        @(posedge clk);
        #1;
        start_in = 1'b0;
        repeat (3) @(negedge clk);
        rst      = 1'b1;
        start_in = 1'b1;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        start_in = 1'b0;
        @(negedge clk);
        checks++; if (state_dbg !== IDLE) begin errors++; $display("FAIL rstmid_state got=%0d want=%0d", state_dbg, IDLE); end
        checks++; if (busy_out !== 1'b0 || done_out !== 1'b0 || dz_out !== 1'b0) begin errors++; $display("FAIL rstmid_flags got=%b%b%b want=000", busy_out, done_out, dz_out); end
        checks++; if (q_out !== '0 || r_out !== '0) begin errors++; $display("FAIL rstmid_result got=%h/%h want=0/0", q_out, r_out); end
        dones = 0;
        repeat (30) begin
            @(negedge clk);
            if (done_out) dones++;
        end
        checks++; if (dones !== 0) begin errors++; $display("FAIL rstmid_no_done got=%0d want=0", dones); end
        drive_op(32'd10, 32'd3, lat, q, r, dz, hs_ok);
        checks++; if (q !== 32'd3 || r !== 32'd1) begin errors++; $display("FAIL rstmid_recover got=%h/%h want=3/1", q, r); end
    endtask

    task automatic test_random();
        logic [WD-1:0] n, d, q, r, eq, er;
        logic dz, edz;
        logic [2*WD:0] exp;
        int lat, elat;
        bit hs_ok;
        for (int i = 0; i < 40; i++) begin
            n = $urandom() >> $urandom_range(0, 31);
            d = $urandom() >> $urandom_range(0, 31);
            if ($urandom_range(0, 9) == 0) d = '0;
            model(n, d, eq, er, edz, elat);
            exp_q.push_back({edz, eq, er});
            drive_op(n, d, lat, q, r, dz, hs_ok);
            exp = exp_q.pop_front();
            checks++; if ({dz, q, r} !== exp) begin errors++; $display("FAIL rand%0d_result n=%h d=%h got=%b/%h/%h want=%b/%h/%h", i, n, d, dz, q, r, exp[2*WD], exp[2*WD-1:WD], exp[WD-1:0]); end
            checks++; if (lat !== elat) begin errors++; $display("FAIL rand%0d_latency n=%h d=%h got=%0d want=%0d", i, n, d, lat, elat); end
            checks++; if (hs_ok !== 1'b1) begin errors++; $display("FAIL rand%0d_busy_done got=%b want=1", i, hs_ok); end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
